// File: rtl/canny_ctrl_pkg.sv
// Shared types and constants for the Canny frame sequencer.
package canny_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    localparam int KERNEL_TAPS  = 9;
    localparam int KERNEL_IDX_W = 4;

endpackage

// File: rtl/valid_delay_line.sv
// Enabled shift register with synchronous clear; carries valid/qualify flags
// alongside the stalled pixel pipeline.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_reg [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (en) begin
            stage_reg[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
    end

    assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/canny_frame_sequencer.sv
// Frame controller for the streaming Canny pipeline: kernel load, raster read, output tagging.
// Optional cycle counters are enabled by defining CANNY_SEQ_PERF_EN.
module canny_frame_sequencer
    import canny_ctrl_pkg::*;
#(
    parameter int IM_WIDTH  = 512,
    parameter int IM_HEIGHT = 512,
    parameter int FRAC_BITS = 10,
    parameter int BORDER    = 6,
    parameter int PIPE_LAT  = 6,
    parameter int ADDR_W    = $clog2(IM_WIDTH*IM_HEIGHT)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [FRAC_BITS-1:0]         i_coef,
    input  logic                         i_coef_valid,
    output logic                         o_kernel_wr_en,
    output logic [KERNEL_IDX_W-1:0]      o_kernel_wr_idx,
    output logic                         o_kernel_valid,
    output logic                         o_rd_en,
    output logic [ADDR_W-1:0]            o_rd_addr,
    output logic                         o_pix_valid,
    output logic                         o_pipe_en,
    input  logic                         i_out_ready,
    output logic                         o_out_valid,
    output logic [$clog2(IM_HEIGHT)-1:0] o_out_row,
    output logic [$clog2(IM_WIDTH)-1:0]  o_out_col,
    output logic                         o_out_last,
    output logic                         o_busy,
    output logic                         o_done
`ifdef CANNY_SEQ_PERF_EN
    ,
    output logic [31:0]                  o_frame_cycles,
    output logic [31:0]                  o_stall_cycles
`endif
);

    localparam int ROW_W = $clog2(IM_HEIGHT);
    localparam int COL_W = $clog2(IM_WIDTH);

    localparam logic [ADDR_W-1:0]       LAST_ADDR    = ADDR_W'(IM_WIDTH*IM_HEIGHT-1);
    localparam logic [COL_W-1:0]        LAST_COL     = COL_W'(IM_WIDTH-1);
    localparam logic [ROW_W-1:0]        BORDER_ROW   = ROW_W'(BORDER);
    localparam logic [COL_W-1:0]        BORDER_COL   = COL_W'(BORDER);
    localparam logic [ROW_W-1:0]        OUT_LAST_ROW = ROW_W'(IM_HEIGHT-BORDER-1);
    localparam logic [COL_W-1:0]        OUT_LAST_COL = COL_W'(IM_WIDTH-BORDER-1);
    localparam logic [KERNEL_IDX_W-1:0] LAST_TAP     = KERNEL_IDX_W'(KERNEL_TAPS-1);

    seq_state_t              state_reg;
    logic [KERNEL_IDX_W-1:0] tap_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [ROW_W-1:0]        rd_row_reg;
    logic [COL_W-1:0]        rd_col_reg;
    logic [ROW_W-1:0]        out_row_reg;
    logic [COL_W-1:0]        out_col_reg;
    logic                    busy_reg;
    logic                    kernel_valid_reg;
    logic                    done_reg;
    logic                    idle_en_reg;

    logic       abort_hit;
    logic       coef_take;
    logic       rd_fire;
    logic       qualify;
    logic       line_clr;
    logic [1:0] pix_line_d;
    logic [1:0] pix_line_q;
    logic       tail_qual;
    logic       out_fire;
    logic       out_last;

    // The kernel register downstream samples i_coef directly on o_kernel_wr_en.
    logic coef_unused;
    assign coef_unused = ^i_coef;

    assign abort_hit = i_abort && (state_reg != S_IDLE);
    assign coef_take = (state_reg == S_LOAD) && i_coef_valid && !i_abort;
    assign rd_fire   = (state_reg == S_STREAM) && i_out_ready;
    assign qualify   = (rd_row_reg >= BORDER_ROW) && (rd_col_reg >= BORDER_COL);
    assign line_clr  = (state_reg == S_IDLE) || abort_hit;

    // Stage 0: read -> pixel valid, with the qualify flag riding alongside.
    assign pix_line_d = {rd_fire & qualify, rd_fire};

    valid_delay_line #(.DEPTH(1), .WIDTH(2)) u_pix_line (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (line_clr),
        .en    (i_out_ready),
        .d     (pix_line_d),
        .q     (pix_line_q)
    );

    valid_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(1)) u_qual_line (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (line_clr),
        .en    (i_out_ready),
        .d     (pix_line_q[1]),
        .q     (tail_qual)
    );

    assign out_fire = tail_qual && i_out_ready;
    assign out_last = out_fire && (out_row_reg == OUT_LAST_ROW) && (out_col_reg == OUT_LAST_COL);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg        <= S_IDLE;
            tap_reg          <= '0;
            addr_reg         <= '0;
            rd_row_reg       <= '0;
            rd_col_reg       <= '0;
            out_row_reg      <= '0;
            out_col_reg      <= '0;
            busy_reg         <= 1'b0;
            kernel_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
            idle_en_reg      <= 1'b0;
        end else begin
            kernel_valid_reg <= 1'b0;
            done_reg         <= 1'b0;
            idle_en_reg      <= 1'b1;

            if (out_fire) begin
                if (out_col_reg == OUT_LAST_COL) begin
                    out_col_reg <= '0;
                    out_row_reg <= out_row_reg + ROW_W'(1);
                end else begin
                    out_col_reg <= out_col_reg + COL_W'(1);
                end
            end

            if (abort_hit) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (i_start) begin
                            state_reg   <= S_LOAD;
                            busy_reg    <= 1'b1;
                            tap_reg     <= '0;
                            addr_reg    <= '0;
                            rd_row_reg  <= '0;
                            rd_col_reg  <= '0;
                            out_row_reg <= '0;
                            out_col_reg <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (coef_take) begin
                            tap_reg <= tap_reg + KERNEL_IDX_W'(1);
                            if (tap_reg == LAST_TAP) begin
                                state_reg        <= S_COMMIT;
                                kernel_valid_reg <= 1'b1;
                            end
                        end
                    end
                    S_COMMIT: state_reg <= S_STREAM;
                    S_STREAM: begin
                        if (rd_fire) begin
                            addr_reg <= addr_reg + ADDR_W'(1);
                            if (rd_col_reg == LAST_COL) begin
                                rd_col_reg <= '0;
                                rd_row_reg <= rd_row_reg + ROW_W'(1);
                            end else begin
                                rd_col_reg <= rd_col_reg + COL_W'(1);
                            end
                            if (addr_reg == LAST_ADDR) state_reg <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (out_last) begin
                            state_reg <= S_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CANNY_SEQ_PERF_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_cycles <= '0;
            o_stall_cycles <= '0;
        end else if (state_reg == S_IDLE) begin
            if (i_start) begin
                o_frame_cycles <= '0;
                o_stall_cycles <= '0;
            end
        end else begin
            o_frame_cycles <= o_frame_cycles + 32'd1;
            if (!i_out_ready) o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

    // pipe_en stays low until the first edge after reset release, then idles high.
    assign o_pipe_en       = busy_reg ? i_out_ready : idle_en_reg;
    assign o_kernel_wr_en  = coef_take;
    assign o_kernel_wr_idx = tap_reg;
    assign o_kernel_valid  = kernel_valid_reg;
    assign o_rd_en         = rd_fire;
    assign o_rd_addr       = addr_reg;
    assign o_pix_valid     = pix_line_q[0];
    assign o_out_valid     = out_fire;
    assign o_out_row       = out_row_reg;
    assign o_out_col       = out_col_reg;
    assign o_out_last      = out_last;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;

endmodule

// File: tb/tb_canny_frame_sequencer.sv
// Randomized bench for canny_frame_sequencer on an 8x8 image against a pixel-index reference model.
module tb_canny_frame_sequencer;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int B     = 6;
    localparam int PL    = 6;
    localparam int FB    = 10;
    localparam int AW    = $clog2(W*H);
    localparam int NPIX  = W*H;
    localparam int LAT   = PL + 1;
    localparam int KTAPS = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FB-1:0] coef = '0;
    logic          coef_valid = 1'b0;
    logic          out_ready = 1'b1;

    logic          kernel_wr_en;
    logic [3:0]    kernel_wr_idx;
    logic          kernel_valid;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pix_valid;
    logic          pipe_en;
    logic          out_valid;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef CANNY_SEQ_PERF_EN
    logic [31:0]   frame_cycles;
    logic [31:0]   stall_cycles;
`endif

    int vec_cnt = 0;
    int miscompare_cnt = 0;

    always #5 clk = ~clk;

    canny_frame_sequencer #(
        .IM_WIDTH(W), .IM_HEIGHT(H), .FRAC_BITS(FB), .BORDER(B), .PIPE_LAT(PL)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_coef(coef), .i_coef_valid(coef_valid),
        .o_kernel_wr_en(kernel_wr_en), .o_kernel_wr_idx(kernel_wr_idx),
        .o_kernel_valid(kernel_valid), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .o_pix_valid(pix_valid), .o_pipe_en(pipe_en), .i_out_ready(out_ready),
        .o_out_valid(out_valid), .o_out_row(out_row), .o_out_col(out_col),
        .o_out_last(out_last), .o_busy(busy), .o_done(done)
`ifdef CANNY_SEQ_PERF_EN
        , .o_frame_cycles(frame_cycles), .o_stall_cycles(stall_cycles)
`endif
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompare_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A pixel produces an output only when it lies outside the lost border.
    function automatic bit qualified(input int a);
        return ((a / W) >= B) && ((a % W) >= B);
    endfunction

    task automatic load_kernel(input bit abort_mid, output int cycles, output bit ok);
        int idx = 0;
        bit aborted = 1'b0;
        cycles = 0;
        ok = 1'b0;
        out_ready = 1'b1;
        abort = 1'b0;
        coef_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_vec("idle_busy", 32'(busy), 0);
        check_vec("idle_pipe_en", 32'(pipe_en), 1);
        tick();
        start = 1'b0;
        while (idx < KTAPS && !aborted && cycles < 200) begin
            coef_valid = ($urandom_range(0, 2) != 0);
            coef = 10'h071 + 10'(idx);
            abort = abort_mid && (idx == 4) && coef_valid;
            @(negedge clk);
            check_vec("load_busy", 32'(busy), 1);
            check_vec("load_wr_en", 32'(kernel_wr_en), 32'(coef_valid && !abort));
            if (coef_valid && !abort) check_vec("load_wr_idx", 32'(kernel_wr_idx), 32'(idx));
            check_vec("load_kvalid", 32'(kernel_valid), 0);
            tick();
            cycles++;
            if (abort) aborted = 1'b1;
            else if (coef_valid) idx++;
        end
        coef_valid = 1'b0;
        abort = 1'b0;
        if (aborted) begin
            @(negedge clk);
            check_vec("load_abort_busy", 32'(busy), 0);
            check_vec("load_abort_kvalid", 32'(kernel_valid), 0);
            tick();
        end else if (idx < KTAPS) begin
            check_vec("load_taps", 32'(idx), KTAPS);
        end else begin
            @(negedge clk);
            check_vec("commit_kvalid", 32'(kernel_valid), 1);
            check_vec("commit_wr_en", 32'(kernel_wr_en), 0);
            check_vec("commit_rd_en", 32'(rd_en), 0);
            tick();
            ok = 1'b1;
        end
    endtask

    // mode 0: sink always ready; 1: ready low on cycles 10..14; 2: random ready.
    task automatic stream_frame(input int mode, input int abort_cyc, input int reset_cyc,
                                output int first_out, output int done_cyc);
        int  n = 0;
        int  a;
        int  last_cyc = -1;
        bit  last_seen = 1'b0;
        bit  ended = 1'b0;
        bit  exp_ov;
        first_out = -1;
        done_cyc = -1;
        for (int cyc = 0; cyc < 1000 && !ended; cyc++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= 10 && cyc <= 14);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            coef_valid = $urandom_range(0, 1) != 0;
            start = last_seen ? 1'b0 : ($urandom_range(0, 1) != 0);
            abort = (cyc == abort_cyc);
            if (cyc == reset_cyc) begin
                #2 rst_n = 1'b0;
                #1;
                check_vec("rst_busy", 32'(busy), 0);
                check_vec("rst_rd_en", 32'(rd_en), 0);
                check_vec("rst_rd_addr", 32'(rd_addr), 0);
                check_vec("rst_pix_valid", 32'(pix_valid), 0);
                check_vec("rst_pipe_en", 32'(pipe_en), 0);
                check_vec("rst_out_valid", 32'(out_valid), 0);
                check_vec("rst_out_rc", 32'({out_row, out_col}), 0);
                check_vec("rst_done", 32'(done), 0);
                check_vec("rst_wr_en", 32'(kernel_wr_en), 0);
                start = 1'b0;
                coef_valid = 1'b0;
                out_ready = 1'b1;
                @(posedge clk);
                #1 rst_n = 1'b1;
                tick();
                @(negedge clk);
                check_vec("post_rst_busy", 32'(busy), 0);
                check_vec("post_rst_pipe_en", 32'(pipe_en), 1);
                check_vec("post_rst_done", 32'(done), 0);
                ended = 1'b1;
            end else begin
                @(negedge clk);
                if (!last_seen) begin
                    check_vec("busy", 32'(busy), 1);
                    check_vec("done", 32'(done), 0);
                    check_vec("pipe_en", 32'(pipe_en), 32'(out_ready));
                    check_vec("wr_en_ignored", 32'(kernel_wr_en), 0);
                    check_vec("rd_en", 32'(rd_en), 32'(out_ready && n < NPIX));
                    if (n < NPIX) check_vec("rd_addr", 32'(rd_addr), 32'(n));
                    check_vec("pix_valid", 32'(pix_valid), 32'(n >= 1 && n <= NPIX));
                    a = n - LAT;
                    exp_ov = out_ready && a >= 0 && a < NPIX && qualified(a);
                    check_vec("out_valid", 32'(out_valid), 32'(exp_ov));
                    if (exp_ov) begin
                        check_vec("out_row", 32'(out_row), 32'(a / W - B));
                        check_vec("out_col", 32'(out_col), 32'(a % W - B));
                        check_vec("out_last", 32'(out_last), 32'(a == NPIX - 1));
                        if (first_out < 0) first_out = cyc;
                        if (a == NPIX - 1) begin
                            last_seen = 1'b1;
                            last_cyc = cyc;
                        end
                    end else begin
                        check_vec("out_last_idle", 32'(out_last), 0);
                    end
                end else if (cyc == last_cyc + 1) begin
                    check_vec("done_pulse", 32'(done), 1);
                    check_vec("done_busy", 32'(busy), 1);
                    check_vec("done_out_valid", 32'(out_valid), 0);
                    done_cyc = cyc;
                end else begin
                    check_vec("end_busy", 32'(busy), 0);
                    check_vec("end_done", 32'(done), 0);
                    check_vec("end_pipe_en", 32'(pipe_en), 1);
                    ended = 1'b1;
                end
                if (abort) begin
                    tick();
                    abort = 1'b0;
                    start = 1'b0;
                    @(negedge clk);
                    check_vec("abort_busy", 32'(busy), 0);
                    check_vec("abort_done", 32'(done), 0);
                    check_vec("abort_rd_en", 32'(rd_en), 0);
                    check_vec("abort_out_valid", 32'(out_valid), 0);
                    tick();
                    @(negedge clk);
                    check_vec("abort_no_done", 32'(done), 0);
                    ended = 1'b1;
                end
                if (out_ready) n++;
            end
            tick();
        end
        start = 1'b0;
        coef_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b1;
        if (!ended) check_vec("frame_timeout", 32'(ended), 1);
    endtask

    initial begin
        int lc;
        int fo;
        int dc;
        bit ok;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("reset_busy", 32'(busy), 0);
        check_vec("reset_pipe_en", 32'(pipe_en), 0);
        check_vec("reset_rd_en", 32'(rd_en), 0);
        check_vec("reset_done", 32'(done), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Plain frame: outputs at 61,62,69,70, done at 71.
        load_kernel(1'b0, lc, ok);
        stream_frame(0, -1, -1, fo, dc);
        $display("frame ready=1: first_out=%0d done=%0d", fo, dc);
        check_vec("s2_first_out", 32'(fo), 61);
        check_vec("s2_done_cyc", 32'(dc), 71);

        // Five-cycle stall shifts everything by five.
        load_kernel(1'b0, lc, ok);
        stream_frame(1, -1, -1, fo, dc);
        $display("frame stall10..14: first_out=%0d done=%0d", fo, dc);
        check_vec("s3_first_out", 32'(fo), 66);
        check_vec("s3_done_cyc", 32'(dc), 76);
`ifdef CANNY_SEQ_PERF_EN
        check_vec("perf_stall", stall_cycles, 5);
        check_vec("perf_frame", frame_cycles, 32'(lc + 1 + dc + 1));
`endif

        // Abort mid-stream, then a clean frame.
        load_kernel(1'b0, lc, ok);
        stream_frame(0, 30, -1, fo, dc);
        $display("frame abort@30: done=%0d", dc);
        check_vec("s4_no_done", 32'(dc), 32'(-1));
        load_kernel(1'b0, lc, ok);
        stream_frame(0, -1, -1, fo, dc);
        $display("frame after abort: first_out=%0d done=%0d", fo, dc);
        check_vec("s4_first_out", 32'(fo), 61);
        check_vec("s4_done_cyc", 32'(dc), 71);

        // Abort during kernel load drops the coincident write.
        load_kernel(1'b1, lc, ok);
        $display("load abort: ok=%0d", ok);
        check_vec("load_abort_ok", 32'(ok), 0);

        // Randomized sink readiness, occasionally aborted.
        for (int f = 0; f < 4; f++) begin
            load_kernel(1'b0, lc, ok);
            stream_frame(2, (f == 2) ? int'($urandom_range(5, 60)) : -1, -1, fo, dc);
            $display("random frame %0d: first_out=%0d done=%0d", f, fo, dc);
        end

        // Async reset in DRAIN, then a full frame must still be correct.
        load_kernel(1'b0, lc, ok);
        stream_frame(0, -1, 66, fo, dc);
        $display("frame reset@66: done=%0d", dc);
        check_vec("s5_no_done", 32'(dc), 32'(-1));
        load_kernel(1'b0, lc, ok);
        stream_frame(0, -1, -1, fo, dc);
        $display("frame after reset: first_out=%0d done=%0d", fo, dc);
        check_vec("s5_first_out", 32'(fo), 61);
        check_vec("s5_done_cyc", 32'(dc), 71);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
